// File: rtl/ntt_bf_sequencer_pkg.sv
// Shared types and constants for the NTT butterfly issue sequencer.
package ntt_bf_sequencer_pkg;

  localparam int NTT_N      = 256;
  localparam int NTT_LAYERS = 7;
  localparam int NTT_BFLY   = NTT_N / 2;

  typedef logic [7:0] ntt_addr_t;
  typedef logic [6:0] zeta_idx_t;
  typedef logic [6:0] bf_idx_t;
  typedef logic [2:0] layer_t;

  localparam logic [3:0] PE_CTRL_NTT  = 4'b0000;
  localparam logic [3:0] PE_CTRL_INTT = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // log2 of the butterfly span for a layer: CT walks 128 down to 2, GS walks 2 up to 128.
  function automatic logic [2:0] layer_log2len(input layer_t layer, input logic inverse);
    return inverse ? (layer + 3'd1) : (3'd7 - layer);
  endfunction

endpackage

// File: rtl/ntt_bf_sequencer_addr_gen.sv
// Combinational butterfly address and twiddle index generator.
// Maps (butterfly, layer, direction) to the pair of in-place RAM indices and the ROM index.
module ntt_addr_gen
  import ntt_bf_sequencer_pkg::*;
(
  input  bf_idx_t   bf_i,
  input  layer_t    layer_i,
  input  logic      mode_i,
  output ntt_addr_t addr0_o,
  output ntt_addr_t addr1_o,
  output zeta_idx_t zeta_idx_o
);

  logic [2:0] s;
  logic [3:0] s_p1;
  logic [7:0] len;
  logic [6:0] grp;
  logic [6:0] g;
  logic [7:0] j;
  logic [6:0] zeta;

  // Group index selects the twiddle; low bits of bf select the position inside the group.
  // The INTT twiddle 2g-1-grp is computed mod 128, which is exact because it never exceeds 127.
  always_comb begin
    s    = layer_log2len(layer_i, mode_i);
    s_p1 = {1'b0, s} + 4'd1;
    len  = 8'd1 << s;
    grp  = bf_i >> s;
    g    = 7'(8'd128 >> s);
    j    = ({1'b0, grp} << s_p1) | ({1'b0, bf_i} & (len - 8'd1));
    zeta = mode_i ? ((g << 1) - 7'd1 - grp) : (g + grp);
  end

  assign addr0_o    = j;
  assign addr1_o    = j + len;
  assign zeta_idx_o = zeta;

endmodule

// File: rtl/ntt_bf_sequencer.sv
// Issue stage for the butterfly PE: walks one NTT/INTT pass over a 256-entry in-place RAM,
// aligns PE valid/ctrl with RAM read data and write-back addresses with PE outputs,
// and drains the PE between layers so no layer reads a word still in flight.
module ntt_bf_sequencer
  import ntt_bf_sequencer_pkg::*;
#(
  parameter int PE_LAT  = 5,
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       stall_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       rd_en_o,
  output ntt_addr_t  rd_addr0_o,
  output ntt_addr_t  rd_addr1_o,
  output zeta_idx_t  zeta_idx_o,
  output logic       pe_valid_o,
  output logic [3:0] pe_ctrl_o,
  output logic       wr_en_o,
  output ntt_addr_t  wr_addr0_o,
  output ntt_addr_t  wr_addr1_o
);

  localparam int DLY   = MEM_LAT + PE_LAT;
  localparam int CNT_W = (DLY > 2) ? $clog2(DLY) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DLY - 1);

  seq_state_e       state_q;
  bf_idx_t          bf_q;
  layer_t           layer_q;
  logic [CNT_W-1:0] drain_q;
  logic             mode_q;

  ntt_addr_t        gen_addr0;
  ntt_addr_t        gen_addr1;
  zeta_idx_t        gen_zeta;

  logic             rd_en_d;
  ntt_addr_t        rd_addr0_d;
  ntt_addr_t        rd_addr1_d;
  zeta_idx_t        zeta_idx_d;
  logic [3:0]       pe_ctrl_d;

  logic [DLY-1:0]   en_pipe_q;
  ntt_addr_t        a0_pipe_q   [DLY];
  ntt_addr_t        a1_pipe_q   [DLY];
  logic [3:0]       ctrl_pipe_q [MEM_LAT];

  ntt_addr_gen u_addr_gen (
    .bf_i       (bf_q),
    .layer_i    (layer_q),
    .mode_i     (mode_q),
    .addr0_o    (gen_addr0),
    .addr1_o    (gen_addr1),
    .zeta_idx_o (gen_zeta)
  );

  // A butterfly issues in any ISSUE cycle the RAM port is free; idle outputs are forced to zero.
  always_comb begin
    rd_en_d    = (state_q == ST_ISSUE) && !stall_i;
    rd_addr0_d = rd_en_d ? gen_addr0 : '0;
    rd_addr1_d = rd_en_d ? gen_addr1 : '0;
    zeta_idx_d = rd_en_d ? gen_zeta  : '0;
    pe_ctrl_d  = '0;
    if (rd_en_d) begin
      pe_ctrl_d = mode_q ? PE_CTRL_INTT : PE_CTRL_NTT;
    end
  end

  // Pass sequencing: issue 128 butterflies, drain the PE, repeat for 7 layers, pulse done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bf_q    <= '0;
      layer_q <= '0;
      drain_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_ISSUE;
            mode_q  <= mode_i;
            bf_q    <= '0;
            layer_q <= '0;
            drain_q <= '0;
          end
        end
        ST_ISSUE: begin
          if (rd_en_d) begin
            bf_q <= bf_q + 7'd1;
            if (bf_q == bf_idx_t'(NTT_BFLY - 1)) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            drain_q <= '0;
            if (layer_q == layer_t'(NTT_LAYERS - 1)) begin
              state_q <= ST_DONE;
            end else begin
              layer_q <= layer_q + 3'd1;
              state_q <= ST_ISSUE;
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          layer_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Delay lines: MEM_LAT taps feed the PE, DLY taps feed write-back; they shift through stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_pipe_q <= '0;
      for (int i = 0; i < DLY; i++) begin
        a0_pipe_q[i] <= '0;
        a1_pipe_q[i] <= '0;
      end
      for (int i = 0; i < MEM_LAT; i++) begin
        ctrl_pipe_q[i] <= '0;
      end
    end else begin
      en_pipe_q    <= {en_pipe_q[DLY-2:0], rd_en_d};
      a0_pipe_q[0] <= rd_addr0_d;
      a1_pipe_q[0] <= rd_addr1_d;
      for (int i = 1; i < DLY; i++) begin
        a0_pipe_q[i] <= a0_pipe_q[i-1];
        a1_pipe_q[i] <= a1_pipe_q[i-1];
      end
      ctrl_pipe_q[0] <= pe_ctrl_d;
      for (int i = 1; i < MEM_LAT; i++) begin
        ctrl_pipe_q[i] <= ctrl_pipe_q[i-1];
      end
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign rd_en_o    = rd_en_d;
  assign rd_addr0_o = rd_addr0_d;
  assign rd_addr1_o = rd_addr1_d;
  assign zeta_idx_o = zeta_idx_d;
  assign pe_valid_o = en_pipe_q[MEM_LAT-1];
  assign pe_ctrl_o  = ctrl_pipe_q[MEM_LAT-1];
  assign wr_en_o    = en_pipe_q[DLY-1];
  assign wr_addr0_o = a0_pipe_q[DLY-1];
  assign wr_addr1_o = a1_pipe_q[DLY-1];

endmodule

// File: tb/tb_ntt_bf_sequencer.sv
// Directed bench for ntt_bf_sequencer: full NTT/INTT passes with and without stalls,
// mid-pass reset, and ignored start pulses.
module tb_ntt_bf_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, mode_i, stall_i;
  logic       busy_o, done_o, rd_en_o, pe_valid_o, wr_en_o;
  logic [7:0] rd_addr0_o, rd_addr1_o, wr_addr0_o, wr_addr1_o;
  logic [6:0] zeta_idx_o;
  logic [3:0] pe_ctrl_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ea0 [2][896];
  logic [7:0]  ea1 [2][896];
  logic [6:0]  ez  [2][896];
  logic [22:0] spot [2][3];

  always #5 clk = ~clk;

  ntt_bf_sequencer #(.PE_LAT(5), .MEM_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .stall_i    (stall_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rd_en_o    (rd_en_o),
    .rd_addr0_o (rd_addr0_o),
    .rd_addr1_o (rd_addr1_o),
    .zeta_idx_o (zeta_idx_o),
    .pe_valid_o (pe_valid_o),
    .pe_ctrl_o  (pe_ctrl_o),
    .wr_en_o    (wr_en_o),
    .wr_addr0_o (wr_addr0_o),
    .wr_addr1_o (wr_addr1_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference loop order of the Kyber NTT/INTT: one entry per butterfly in issue order.
  task automatic build_model();
    int idx, k;
    idx = 0;
    k   = 1;
    for (int len = 128; len >= 2; len = len / 2) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          ea0[0][idx] = 8'(j);
          ea1[0][idx] = 8'(j + len);
          ez[0][idx]  = 7'(k);
          idx++;
        end
        k++;
      end
    end
    idx = 0;
    k   = 127;
    for (int len = 2; len <= 128; len = len * 2) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          ea0[1][idx] = 8'(j);
          ea1[1][idx] = 8'(j + len);
          ez[1][idx]  = 7'(k);
          idx++;
        end
        k--;
      end
    end
    // Hand-derived: first issue, first issue of the last layer, last issue.
    spot[0][0] = {8'd0,   8'd128, 7'd1};
    spot[0][1] = {8'd0,   8'd2,   7'd64};
    spot[0][2] = {8'd253, 8'd255, 7'd127};
    spot[1][0] = {8'd0,   8'd2,   7'd127};
    spot[1][1] = {8'd0,   8'd128, 7'd1};
    spot[1][2] = {8'd127, 8'd255, 7'd1};
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, 32'({busy_o, done_o, rd_en_o, pe_valid_o, wr_en_o}), 32'd0);
    chk({tag, "_rd"},  32'({rd_addr0_o, rd_addr1_o, zeta_idx_o}), 32'd0);
    chk({tag, "_pe"},  32'(pe_ctrl_o), 32'd0);
    chk({tag, "_wr"},  32'({wr_addr0_o, wr_addr1_o}), 32'd0);
  endtask

  task automatic run_pass(input logic m, input int pct, input logic repulse);
    int   iss, wcnt, dones, done_cyc, post, d, bad_cov, sidx;
    logic prev_rd;
    int   issq[$];
    int   wr_cnt [7][256];
    for (int l = 0; l < 7; l++)
      for (int a = 0; a < 256; a++) wr_cnt[l][a] = 0;
    iss = 0; wcnt = 0; dones = 0; done_cyc = 0; post = 0; prev_rd = 1'b0;

    @(negedge clk);
    mode_i  = m;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    mode_i  = ~m;
    for (int k = 1; k <= 6000; k++) begin
      start_i = repulse && (k == 300);
      stall_i = (pct > 0) && ($urandom_range(99) < pct);
      #1;
      if (stall_i) chk("stall_rd_en", 32'(rd_en_o), 32'd0);
      chk("pe_valid", 32'(pe_valid_o), 32'(prev_rd));
      if (rd_en_o) begin
        if (iss < 896) begin
          chk("rd_seq", 32'({rd_addr0_o, rd_addr1_o, zeta_idx_o}),
              32'({ea0[m][iss], ea1[m][iss], ez[m][iss]}));
          sidx = (iss == 0) ? 0 : (iss == 768) ? 1 : (iss == 895) ? 2 : -1;
          if (sidx >= 0) chk("rd_spot", 32'({rd_addr0_o, rd_addr1_o, zeta_idx_o}), 32'(spot[m][sidx]));
          issq.push_back(k);
        end else begin
          chk("rd_extra", 32'd1, 32'd0);
        end
        iss++;
      end
      if (pe_valid_o) chk("pe_ctrl", 32'(pe_ctrl_o), 32'({3'b000, m}));
      if (wr_en_o) begin
        if (issq.size() > 0 && wcnt < 896) begin
          d = k - issq.pop_front();
          chk("wr_delay", 32'(d), 32'd6);
          chk("wr_addr", 32'({wr_addr0_o, wr_addr1_o}), 32'({ea0[m][wcnt], ea1[m][wcnt]}));
          wr_cnt[wcnt / 128][wr_addr0_o]++;
          wr_cnt[wcnt / 128][wr_addr1_o]++;
        end else begin
          chk("wr_extra", 32'd1, 32'd0);
        end
        wcnt++;
      end
      if (done_o) begin
        dones++;
        done_cyc = k;
        chk("busy_at_done", 32'(busy_o), 32'd1);
        if (repulse) start_i = 1'b1;
      end else if (dones > 0) begin
        chk("busy_after_done", 32'(busy_o), 32'd0);
        post++;
      end
      prev_rd = rd_en_o;
      if (post >= 5) break;
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    stall_i = 1'b0;
    chk("issue_count", 32'(iss), 32'd896);
    chk("write_count", 32'(wcnt), 32'd896);
    chk("done_count", 32'(dones), 32'd1);
    if (pct == 0) chk("done_cycle", 32'(done_cyc), 32'd939);
    bad_cov = 0;
    for (int l = 0; l < 7; l++)
      for (int a = 0; a < 256; a++)
        if (wr_cnt[l][a] != 1) bad_cov++;
    chk("write_once", 32'(bad_cov), 32'd0);
  endtask

  task automatic reset_mid_pass();
    int wr_seen, done_seen, busy_seen;
    @(negedge clk);
    mode_i  = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (399) @(posedge clk);
    #2;
    chk("busy_before_rst", 32'(busy_o), 32'd1);
    chk("wr_en_before_rst", 32'(wr_en_o), 32'd1);
    rst = 1'b0;
    #1;
    chk_outputs_zero("rst_mid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wr_seen = 0; done_seen = 0; busy_seen = 0;
    repeat (1200) begin
      @(posedge clk);
      #1;
      if (wr_en_o) wr_seen++;
      if (done_o) done_seen++;
      if (busy_o) busy_seen++;
    end
    chk("post_rst_wr_en", 32'(wr_seen), 32'd0);
    chk("post_rst_done", 32'(done_seen), 32'd0);
    chk("post_rst_busy", 32'(busy_seen), 32'd0);
  endtask

  initial begin
    build_model();
    rst     = 1'b0;
    start_i = 1'b0;
    mode_i  = 1'b0;
    stall_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs_zero("idle");

    run_pass(1'b0, 0, 1'b0);
    run_pass(1'b1, 0, 1'b0);
    run_pass(1'b0, 30, 1'b0);
    run_pass(1'b1, 30, 1'b0);
    reset_mid_pass();
    run_pass(1'b0, 0, 1'b0);
    run_pass(1'b1, 0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("final_busy", 32'(busy_o), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
